spi_fb_scanout: RTL and testbench
=================================

SPI_FB_SCANOUT -- requirements
Module: spi_fb_scanout

Interface
REQ-001 Parameter: CLK_DIV, default 2, SCLK half-period in CLK cycles; legal range 1..255.
REQ-002 Parameter: NUM_PIXELS, default 76800, pixels per frame (320x240); legal range 1..131072.
REQ-003 Parameter: RAMWR_CMD, default 8'h2C, display memory-write command byte sent before each frame.
REQ-004 Port: CLK  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: RST  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 Port: START  input  1  frame request; sampled only in IDLE.
REQ-007 Port: ADDR2  output  17  framebuffer read address (pixel index).
REQ-008 Port: RD2  input  16  framebuffer read data; valid on the first rising edge after ADDR2 is presented (1-cycle registered read).
REQ-009 Port: SCLK  output  1  SPI clock, mode 0 (idle low, data sampled by display on rising edge).
REQ-010 Port: MOSI  output  1  SPI data, MSB first.
REQ-011 Port: CS_N  output  1  display chip select, active low.
REQ-012 Port: DC  output  1  data/command select; 0 = command byte, 1 = pixel data.
REQ-013 Port: BUSY  output  1  high from the cycle after START is accepted until DONE.
REQ-014 Port: DONE  output  1  one-cycle pulse after the last pixel bit completes.

Function
REQ-015 States SHALL be IDLE, CMD, PIX, FINISH; IDLE -> CMD on START; CMD -> PIX after 8 bits; PIX -> FINISH after NUM_PIXELS*16 bits; FINISH -> IDLE after one cycle.
REQ-016 On the cycle after START is sampled high in IDLE: CS_N=0, DC=0, BUSY=1, MOSI=RAMWR_CMD[7], SCLK=0.
REQ-017 Each bit period SHALL be exactly 2*CLK_DIV CLK cycles: SCLK low for CLK_DIV cycles then high for CLK_DIV cycles; MOSI and DC change only while SCLK is low, at the start of a bit period.
REQ-018 CMD state SHALL shift RAMWR_CMD MSB first with DC=0.
REQ-019 PIX state SHALL shift pixels index 0..NUM_PIXELS-1 in order, each 16 bits MSB first, DC=1.
REQ-020 SCLK SHALL run gaplessly from the first command bit to the last pixel bit: bit 0 of one word is immediately followed by bit 15 of the next word (no idle bit periods), including the command-to-pixel-0 transition.
REQ-021 The block SHALL prefetch: ADDR2 is driven with pixel index n at least 2 CLK cycles before pixel n is loaded into the shifter; RD2 is captured into a holding register exactly one cycle after ADDR2 changes.
REQ-022 ADDR2 SHALL never exceed NUM_PIXELS-1; after the last fetch ADDR2 holds NUM_PIXELS-1 until FINISH, then returns to 0.
REQ-023 Bit and pixel counters SHALL be wide enough that no wrap occurs within a frame (pixel counter 17 bits).
REQ-024 After the final bit's SCLK high phase ends: SCLK=0, CS_N=1, BUSY=0, DONE=1 for exactly one cycle (FINISH), DC returns to 0.
REQ-025 START asserted while BUSY=1 or in FINISH SHALL be ignored (not queued).
REQ-026 START held high continuously SHALL start a new frame on the first IDLE cycle after FINISH (back-to-back frames; CS_N high for at least one cycle between frames).
REQ-027 Total SCLK rising edges per frame SHALL equal 8 + 16*NUM_PIXELS.

Reset
REQ-028 While RST=1 at a rising edge, next-cycle outputs SHALL be: state IDLE, ADDR2=0, SCLK=0, MOSI=0, CS_N=1, DC=0, BUSY=0, DONE=0, all counters and shift/holding registers 0.
REQ-029 RST SHALL take priority over START and over any in-progress frame; a frame aborted by reset produces no DONE pulse.

Verification
REQ-030 NUM_PIXELS=4, CLK_DIV=1, RD2 model returns 16'hA000+addr with 1-cycle latency, pulse START -> 8+64=72 SCLK rising edges, sampled MOSI = 0x2C, A000, A001, A002, A003; DC=0 for first 8 edges, 1 after; one DONE pulse.
REQ-031 CLK_DIV=3, NUM_PIXELS=2 -> every SCLK high and low phase exactly 3 CLK cycles; no gap between command and pixel 0 or between pixels; frame length 40*6=240 cycles CS_N low.
REQ-032 Assert RST during pixel 1 of a 4-pixel frame -> next cycle CS_N=1, SCLK=0, BUSY=0, ADDR2=0; no DONE; fresh START then sends full correct frame.
REQ-033 Pulse START again mid-frame -> ignored; exactly one frame and one DONE; START held high -> two consecutive frames separated by >=1 cycle of CS_N=1.
REQ-034 NUM_PIXELS=1 with RD2 returning 16'hFFFF then 16'h0001 on re-read -> frame carries 0x2C, FFFF; ADDR2 never leaves 0; then NUM_PIXELS=76800 full-frame run -> 1228808 SCLK edges, max ADDR2=76799.

Source files
------------

// File: rtl/spi_fb_scanout.sv
// Streams one framebuffer frame to an SPI display: a memory-write command byte
// followed by NUM_PIXELS 16-bit pixels, with SCLK running gaplessly throughout.
module spi_fb_scanout #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned NUM_PIXELS = 76800,
  parameter logic [7:0]  RAMWR_CMD  = 8'h2C
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic [16:0] ADDR2,
  input  logic [15:0] RD2,
  output logic        SCLK,
  output logic        MOSI,
  output logic        CS_N,
  output logic        DC,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [16:0] LAST_PIX = 17'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PIX, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [16:0] pix_q, pix_d;
  logic [16:0] addr_q, addr_d;
  logic [15:0] sh_q, sh_d;
  logic [15:0] hold_q, hold_d;
  logic        fetch_q, fetch_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        csn_q, csn_d;
  logic        dc_q, dc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    hold_d  = fetch_q ? RD2 : hold_q;
    fetch_d = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    dc_d    = dc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (START) begin
          state_d = S_CMD;
          csn_d   = 1'b0;
          dc_d    = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          pix_d   = '0;
          mosi_d  = RAMWR_CMD[7];
          sh_d    = {RAMWR_CMD[6:0], 9'b0};
          bit_d   = 4'd7;
          fetch_d = 1'b1;          // pixel 0 address is already on ADDR2
        end
      end

      S_CMD, S_PIX: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 4'd0) begin
              mosi_d = sh_q[15];
              sh_d   = {sh_q[14:0], 1'b0};
              bit_d  = bit_q - 4'd1;
            end else if (state_q == S_PIX && pix_q == LAST_PIX) begin
              state_d = S_FINISH;
              csn_d   = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              dc_d    = 1'b0;
              mosi_d  = 1'b0;
            end else begin
              // Load the prefetched word and immediately request the next one.
              state_d = S_PIX;
              dc_d    = 1'b1;
              mosi_d  = hold_q[15];
              sh_d    = {hold_q[14:0], 1'b0};
              bit_d   = 4'd15;
              if (state_q == S_PIX) pix_d = pix_q + 17'd1;
              if (addr_q != LAST_PIX) begin
                addr_d  = addr_q + 17'd1;
                fetch_d = 1'b1;
              end
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        addr_d  = '0;
        div_d   = '0;
        bit_d   = '0;
        pix_d   = '0;
        sh_d    = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      hold_q  <= '0;
      fetch_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      fetch_q <= fetch_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      dc_q    <= dc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ADDR2 = addr_q;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;
  assign CS_N  = csn_q;
  assign DC    = dc_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_spi_fb_scanout.sv
// Self-checking bench for spi_fb_scanout: four parameterisations, a word-level
// scoreboard fed at START and drained as SPI words complete on the wire.
module tb_spi_fb_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [4];
  logic [16:0] addr  [4];
  logic [15:0] rd2   [4];
  logic        sclk  [4];
  logic        mosi  [4];
  logic        csn   [4];
  logic        dc    [4];
  logic        busy  [4];
  logic        done  [4];

  always #5 clk = ~clk;

  spi_fb_scanout #(.CLK_DIV(1), .NUM_PIXELS(4)) u0 (
    .CLK(clk), .RST(rst), .START(start[0]), .ADDR2(addr[0]), .RD2(rd2[0]),
    .SCLK(sclk[0]), .MOSI(mosi[0]), .CS_N(csn[0]), .DC(dc[0]), .BUSY(busy[0]), .DONE(done[0]));
  spi_fb_scanout #(.CLK_DIV(3), .NUM_PIXELS(2)) u1 (
    .CLK(clk), .RST(rst), .START(start[1]), .ADDR2(addr[1]), .RD2(rd2[1]),
    .SCLK(sclk[1]), .MOSI(mosi[1]), .CS_N(csn[1]), .DC(dc[1]), .BUSY(busy[1]), .DONE(done[1]));
  spi_fb_scanout #(.CLK_DIV(1), .NUM_PIXELS(1)) u2 (
    .CLK(clk), .RST(rst), .START(start[2]), .ADDR2(addr[2]), .RD2(rd2[2]),
    .SCLK(sclk[2]), .MOSI(mosi[2]), .CS_N(csn[2]), .DC(dc[2]), .BUSY(busy[2]), .DONE(done[2]));
  spi_fb_scanout #(.CLK_DIV(1), .NUM_PIXELS(300)) u3 (
    .CLK(clk), .RST(rst), .START(start[3]), .ADDR2(addr[3]), .RD2(rd2[3]),
    .SCLK(sclk[3]), .MOSI(mosi[3]), .CS_N(csn[3]), .DC(dc[3]), .BUSY(busy[3]), .DONE(done[3]));

  // Framebuffer models: data for the presented address is ready by the next rising edge.
  // Instance 2 returns FFFF on the first read of a frame and 0001 on any later read.
  int rr_cnt = 0;
  always @(negedge clk) begin
    rd2[0] <= 16'hA000 + addr[0][15:0];
    rd2[1] <= 16'hA000 + addr[1][15:0];
    rd2[3] <= 16'hA000 + addr[3][15:0];
    if (csn[2] !== 1'b0) begin
      rr_cnt <= 0;
      rd2[2] <= 16'hFFFF;
    end else begin
      rr_cnt <= rr_cnt + 1;
      rd2[2] <= (rr_cnt == 0) ? 16'hFFFF : 16'h0001;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int np_of  [4];
  int div_of [4];

  logic [15:0] expq [$];

  int          sel;
  logic        prev_s, prev_c;
  logic [15:0] wacc;
  logic [3:0]  done_state;
  int edges, csl, run, phase_bad, dc_bad, done_cnt, frames, gap, gap_min;
  int bits, word_idx, max_addr, addr_bad;

  typedef struct {
    int inst;
    bit extra_start;
    int exp_edges;
    int exp_csl;
    int exp_maxa;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    prev_s = 1'b0; prev_c = 1'b1; wacc = '0; done_state = '0;
    edges = 0; csl = 0; run = 0; phase_bad = 0; dc_bad = 0; done_cnt = 0;
    frames = 0; gap = 0; gap_min = 1000; bits = 0; word_idx = 0;
    max_addr = 0; addr_bad = 0;
  endtask

  // Advance one clock and sample the selected DUT half a cycle after the edge.
  task automatic tick();
    logic s, c, m, d;
    @(negedge clk);
    s = sclk[sel]; c = csn[sel]; m = mosi[sel]; d = dc[sel];
    if (!c) csl++;
    if (!c && !prev_c) begin
      if (s == prev_s) run++;
      else begin
        if (run != div_of[sel]) phase_bad++;
        run = 1;
      end
    end else if (!c && prev_c) begin
      run = 1;
      if (s) phase_bad++;
      if (frames > 0 && gap < gap_min) gap_min = gap;
      gap = 0; bits = 0; word_idx = 0; wacc = '0;
    end else if (c && !prev_c) begin
      if (run != div_of[sel] || !prev_s) phase_bad++;
      gap = 1;
    end else begin
      gap++;
      if (s) phase_bad++;
    end
    if (!c && s && !prev_s) begin
      edges++;
      wacc = {wacc[14:0], m};
      if (d != (word_idx != 0)) dc_bad++;
      bits++;
      if (bits == ((word_idx == 0) ? 8 : 16)) begin
        if (expq.size() == 0) check("word_queue_size", 32'(expq.size()), 32'd1);
        else check($sformatf("word%0d", word_idx), 32'(wacc), 32'(expq.pop_front()));
        bits = 0;
        word_idx++;
      end
    end
    if (done[sel]) begin
      done_cnt++;
      frames++;
      done_state = {c, busy[sel], s, d};
    end
    if (32'(addr[sel]) > max_addr) max_addr = 32'(addr[sel]);
    if (32'(addr[sel]) >= np_of[sel]) addr_bad++;
    prev_s = s; prev_c = c;
  endtask

  task automatic push_frame(input int k);
    expq.push_back(16'h002C);
    for (int p = 0; p < np_of[k]; p++)
      expq.push_back((k == 2) ? 16'hFFFF : 16'(32'hA000 + p));
  endtask

  task automatic run_frame(input int k, input bit extra, input int e_edges, input int e_csl,
                           input int e_maxa);
    int budget;
    sel = k;
    clear_mon();
    push_frame(k);
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
    check("first_cycle", 32'({csn[k], dc[k], busy[k], mosi[k], sclk[k]}), 32'b00100);
    budget = 2 * div_of[k] * (8 + 16 * np_of[k]) + 50;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      if (extra && i == 40) start[k] = 1'b1;
      if (extra && i == 41) start[k] = 1'b0;
      tick();
    end
    for (int i = 0; i < 6; i++) tick();
    check("done_count", 32'(done_cnt), 32'd1);
    check("sclk_edges", 32'(edges), 32'(e_edges));
    check("cs_low_cycles", 32'(csl), 32'(e_csl));
    check("done_cycle_outputs", 32'(done_state), 32'b1000);
    check("phase_errors", 32'(phase_bad), 32'd0);
    check("dc_errors", 32'(dc_bad), 32'd0);
    check("words_left", 32'(expq.size()), 32'd0);
    check("max_addr", 32'(max_addr), 32'(e_maxa));
    check("addr_range_errors", 32'(addr_bad), 32'd0);
    check("addr_after_frame", 32'(addr[k]), 32'd0);
    check("cs_idle_after_frame", 32'(csn[k]), 32'd1);
    expq.delete();
  endtask

  initial begin
    np_of  = '{4, 2, 1, 300};
    div_of = '{1, 3, 1, 1};
    vecs[0] = '{inst: 0, extra_start: 1'b0, exp_edges: 72,   exp_csl: 144,  exp_maxa: 3};
    vecs[1] = '{inst: 1, extra_start: 1'b0, exp_edges: 40,   exp_csl: 240,  exp_maxa: 1};
    vecs[2] = '{inst: 2, extra_start: 1'b0, exp_edges: 24,   exp_csl: 48,   exp_maxa: 0};
    vecs[3] = '{inst: 3, extra_start: 1'b0, exp_edges: 4808, exp_csl: 9616, exp_maxa: 299};
    vecs[4] = '{inst: 0, extra_start: 1'b1, exp_edges: 72,   exp_csl: 144,  exp_maxa: 3};

    sel = 0;
    clear_mon();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) start[k] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset_outputs_u%0d", k),
            32'({csn[k], sclk[k], mosi[k], dc[k], busy[k], done[k]}), 32'b100000);
      check($sformatf("reset_addr_u%0d", k), 32'(addr[k]), 32'd0);
    end
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_frame(vecs[i].inst, vecs[i].extra_start, vecs[i].exp_edges, vecs[i].exp_csl,
                vecs[i].exp_maxa);

    // Reset in the middle of pixel 1 aborts the frame without DONE.
    sel = 0;
    clear_mon();
    push_frame(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 200 && edges < 29; i++) tick();
    check("abort_edge", 32'(edges), 32'd29);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", 32'({csn[0], sclk[0], busy[0], done[0], dc[0], mosi[0]}), 32'b100000);
    check("abort_addr", 32'(addr[0]), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    expq.delete();
    run_frame(0, 1'b0, 72, 144, 3);

    // START held high: two back-to-back frames with CS_N released between them.
    sel = 0;
    clear_mon();
    push_frame(0);
    push_frame(0);
    start[0] = 1'b1;
    for (int i = 0; i < 400 && done_cnt < 1; i++) tick();
    for (int i = 0; i < 10 && !(prev_c == 1'b0); i++) tick();
    start[0] = 1'b0;
    for (int i = 0; i < 400 && done_cnt < 2; i++) tick();
    for (int i = 0; i < 6; i++) tick();
    check("held_done_count", 32'(done_cnt), 32'd2);
    check("held_sclk_edges", 32'(edges), 32'd144);
    check("held_cs_low_cycles", 32'(csl), 32'd288);
    check("held_gap_at_least_1", 32'(gap_min >= 1 && gap_min < 1000), 32'd1);
    check("held_phase_errors", 32'(phase_bad), 32'd0);
    check("held_words_left", 32'(expq.size()), 32'd0);
    check("held_cs_idle_after", 32'(csn[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
